tt_sweep_ctrl: RTL
==================

# tt_sweep_ctrl

Sequencer that characterises one 3-input combinational gate, for example a truth-table module such as the 0x6C gate. On a start pulse it drives all eight input combinations into the gate in order and waits a programmable settle time before sampling each output. It assembles the eight samples into an 8-bit signature in the same hex convention used for gate names, then compares it against an expected value. It sits between a test or configuration host and the gate's in1/in2/in3/out pins.

## Interface
- SETTLE_CYCLES, default 4: cycles each input vector is held before the output is sampled; legal range 1..255.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  stops an in-progress sweep; honoured in SETTLE and SAMPLE.
- expected  input  8  expected signature; captured on the edge that accepts start.
- dut_in  output  3  drive to the gate under test: bit2 = in1, bit1 = in2, bit0 = in3.
- dut_out  input  1  the gate's out pin.
- busy  output  1  high while in SETTLE or SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes; never pulses on abort.
- pass  output  1  registered result of signature == captured expected; valid from done onward.
- signature  output  8  captured truth table; bit (7 − idx) holds the output for input vector idx.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Internal registers:
  - idx, 3 bits: current vector.
  - cnt: settle counter, $clog2(SETTLE_CYCLES+1) bits.
  - exp_q, 8 bits: captured expected value.
- IDLE:
  - dut_in = 0; busy = 0.
  - start = 1 → exp_q ← expected, idx ← 0, cnt ← 0, signature ← 0, pass ← 0, go to SETTLE.
- SETTLE:
  - dut_in = idx; cnt increments every cycle.
  - cnt == SETTLE_CYCLES−1 → go to SAMPLE.
- SAMPLE:
  - signature[7−idx] ← dut_out.
  - idx == 7 → go to DONE.
  - Otherwise idx ← idx+1, cnt ← 0, go to SETTLE.
  - dut_in changes to the new idx on the same edge.
- DONE:
  - done = 1; pass ← (signature with the final sample) == exp_q.
  - Go to IDLE next cycle.
- abort in SETTLE or SAMPLE:
  - Go to IDLE next edge; dut_in ← 0; pass ← 0; no done pulse.
  - signature keeps the bits captured so far.
  - abort wins over a same-cycle SAMPLE write.
- start outside IDLE is ignored, including in DONE, and is not queued.
- abort in IDLE or DONE is ignored.
- With this bit ordering, a correct 0x6C gate yields signature 8'h6C; the signature equals the gate's hex name.

## Timing
- Reset values: state IDLE, dut_in 3'b000, busy 0, done 0, pass 0, signature 8'h00, idx 0, cnt 0.
- reset wins over start and abort on the same edge. Reset mid-sweep returns everything to reset values on that edge.
- Each vector lasts SETTLE_CYCLES+1 cycles: SETTLE_CYCLES settle cycles plus 1 sample cycle.
- Edge E accepts start. Then:
  - busy is high from E+1 through E+8·(SETTLE_CYCLES+1).
  - done is high for exactly one cycle, starting 8·(SETTLE_CYCLES+1) edges after E.
  - With default SETTLE_CYCLES = 4, done follows E by 40 edges.
- The earliest next start is accepted on the edge after done falls, i.e. once back in IDLE.
- pass and signature hold their values until the next accepted start or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then model a 0x6C gate; start with expected = 8'h6C, SETTLE_CYCLES = 4 → dut_in steps through 0..7, each held 5 cycles. done pulses 40 edges after start; signature = 8'h6C, pass = 1.
- Same gate with expected = 8'h96 → done at the same cycle; signature = 8'h6C, pass = 0.
- Model a gate with 3-cycle output delay, SETTLE_CYCLES = 4 → signature = 8'h6C. Repeat with SETTLE_CYCLES = 2 → signature ≠ 8'h6C, pass = 0.
- Assert abort while idx = 3 → next cycle busy = 0, dut_in = 0, pass = 0. No done ever pulses; signature[7:5] hold the first three samples (3'b011 for 0x6C) and signature[4:0] = 0.
- Pulse start again while busy, and also during DONE → ignored; exactly one done per accepted start.
- Assert reset at idx = 5, and also on a start cycle → all outputs return to reset values on that edge; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps a 3-input gate through all eight vectors and checks its truth-table signature.
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic [2:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_d;
  logic [2:0] idx, idx_d, dut_in_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] exp_q, exp_d, sig_d;
  logic load, run, smp, pass_d, busy_d, done_d;
  always_ff @(posedge clk) state <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? SETTLE : IDLE;
      SETTLE:  state_d = abort ? IDLE : (cnt == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      SAMPLE:  state_d = abort ? IDLE : (idx == 3'd7) ? DONE : SETTLE;
      default: state_d = IDLE;
    endcase
  end
  // Next values of every registered output, so nothing combinational reaches a port.
  always_comb begin
    load     = state == IDLE && start;
    run      = state == SETTLE || state == SAMPLE;
    smp      = state == SAMPLE && !abort;
    idx_d    = load ? 3'd0 : (smp && idx != 3'd7) ? idx + 3'd1 : idx;
    cnt_d    = (load || state == SAMPLE) ? '0 : (state == SETTLE) ? cnt + 1'b1 : cnt;
    sig_d    = load ? 8'h00 : smp ? (signature | ({dut_out, 7'd0} >> idx)) : signature;
    exp_d    = load ? expected : exp_q;
    pass_d   = (load || (run && abort)) ? 1'b0 : (smp && idx == 3'd7) ? (sig_d == exp_q) : pass;
    busy_d   = state_d == SETTLE || state_d == SAMPLE;
    done_d   = state_d == DONE;
    dut_in_d = busy_d ? idx_d : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      signature <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_in    <= '0;
    end else begin
      idx       <= idx_d;
      cnt       <= cnt_d;
      exp_q     <= exp_d;
      signature <= sig_d;
      pass      <= pass_d;
      busy      <= busy_d;
      done      <= done_d;
      dut_in    <= dut_in_d;
    end
  end
endmodule
